// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the 128-bit line fetch master: CTI codes,
// FSM state type and the bus word type.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StSingle,
        StBurst,
        StResp
    } state_e;

    typedef logic [127:0] word_t;

endpackage

// File: rtl/wb_line_fetch128_if.sv
// Wishbone bus bundle between the line fetch master and the 128-bit slaves.
interface wb_line_fetch128_if #(
    parameter int unsigned AW = 32
);
    import wb_pkg::*;

    logic          cyc;
    logic          stb;
    logic [2:0]    cti;
    logic          we;
    logic [15:0]   sel;
    logic [AW-1:0] adr;
    word_t         dat_w;
    logic          ack;
    word_t         dat_r;

    modport master (
        output cyc, stb, cti, we, sel, adr, dat_w,
        input  ack, dat_r
    );

    modport slave (
        input  cyc, stb, cti, we, sel, adr, dat_w,
        output ack, dat_r
    );

endinterface

// File: rtl/wb_line_fetch_tmo.sv
// Bus timeout counter: cleared on ack or while idle, counts stalled cycles and
// flags the cycle in which the limit is reached.
module wb_line_fetch_tmo #(
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tmo_o
);

    localparam int unsigned CntW = ($clog2(TMO_CYCLES + 1) > 8) ? $clog2(TMO_CYCLES + 1) : 8;

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the stalled cycle that brings the count up to the limit.
    assign tmo_o = inc_i && !clr_i && (cnt_q == CntW'(TMO_CYCLES - 1));

endmodule

// File: rtl/wb_line_fetch128.sv
// Wishbone master issuing single 128-bit accesses or incrementing line bursts.
// Optional bus timeout enabled by defining WB_LINE_FETCH128_TMO_EN.
module wb_line_fetch128
    import wb_pkg::*;
#(
    parameter int unsigned BEATS      = 4,
    parameter int unsigned AW         = 32,
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    input  logic                   req_line_i,
    input  logic                   req_we_i,
    input  logic [15:0]            req_sel_i,
    input  logic [AW-1:0]          req_adr_i,
    input  word_t                  req_dat_i,
    output logic                   req_rdy_o,
    output logic                   resp_vld_o,
    output logic                   resp_err_o,
    output logic [128*BEATS-1:0]   resp_dat_o,
    wb_line_fetch128_if.master     wb
);

    localparam int unsigned BW = $clog2(BEATS);
    localparam logic [AW-1:0] LineMask = ~AW'((1 << (BW + 4)) - 1);

    state_e               state_q;
    logic                 cyc_q;
    logic [2:0]           cti_q;
    logic                 we_q;
    logic [15:0]          sel_q;
    logic [AW-1:0]        adr_q;
    word_t                dat_q;
    logic [BW-1:0]        beat_q;
    logic [128*BEATS-1:0] line_q, line_d;
    logic [128*BEATS-1:0] resp_dat_q;
    logic                 resp_vld_q;
    logic                 resp_err_q;
    logic                 tmo;

`ifdef WB_LINE_FETCH128_TMO_EN
    wb_line_fetch_tmo #(
        .TMO_CYCLES(TMO_CYCLES)
    ) u_tmo (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr_i(wb.ack || (state_q == StIdle)),
        .inc_i(cyc_q && !wb.ack),
        .tmo_o(tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    // Line being assembled with the current beat merged in.
    always_comb begin
        line_d = line_q;
        line_d[beat_q*128 +: 128] = wb.dat_r;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cyc_q      <= 1'b0;
            cti_q      <= CTI_CLASSIC;
            we_q       <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            beat_q     <= '0;
            line_q     <= '0;
            resp_dat_q <= '0;
            resp_vld_q <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            resp_vld_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_i) begin
                        cyc_q  <= 1'b1;
                        beat_q <= '0;
                        dat_q  <= req_dat_i;
                        if (req_line_i) begin
                            state_q <= StBurst;
                            cti_q   <= CTI_INCR;
                            we_q    <= 1'b0;
                            sel_q   <= '1;
                            adr_q   <= req_adr_i & LineMask;
                        end else begin
                            state_q <= StSingle;
                            cti_q   <= CTI_CLASSIC;
                            we_q    <= req_we_i;
                            sel_q   <= req_sel_i;
                            adr_q   <= req_adr_i;
                        end
                    end
                end
                StSingle: begin
                    if (wb.ack) begin
                        cyc_q      <= 1'b0;
                        state_q    <= StResp;
                        resp_vld_q <= 1'b1;
                        resp_err_q <= 1'b0;
                        if (!we_q) begin
                            resp_dat_q[127:0] <= wb.dat_r;
                        end
                    end else if (tmo) begin
                        cyc_q      <= 1'b0;
                        state_q    <= StResp;
                        resp_vld_q <= 1'b1;
                        resp_err_q <= 1'b1;
                    end
                end
                StBurst: begin
                    if (wb.ack) begin
                        line_q <= line_d;
                        if (beat_q == BW'(BEATS - 1)) begin
                            cyc_q      <= 1'b0;
                            cti_q      <= CTI_CLASSIC;
                            state_q    <= StResp;
                            resp_dat_q <= line_d;
                            resp_vld_q <= 1'b1;
                            resp_err_q <= 1'b0;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                            adr_q  <= adr_q + AW'(16);
                            cti_q  <= (beat_q == BW'(BEATS - 2)) ? CTI_EOB : CTI_INCR;
                        end
                    end else if (tmo) begin
                        cyc_q      <= 1'b0;
                        cti_q      <= CTI_CLASSIC;
                        state_q    <= StResp;
                        resp_dat_q <= line_q;
                        resp_vld_q <= 1'b1;
                        resp_err_q <= 1'b1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_rdy_o  = (state_q == StIdle);
    assign resp_vld_o = resp_vld_q;
    assign resp_err_o = resp_err_q;
    assign resp_dat_o = resp_dat_q;

    assign wb.cyc   = cyc_q;
    assign wb.stb   = cyc_q;
    assign wb.cti   = cti_q;
    assign wb.we    = we_q;
    assign wb.sel   = sel_q;
    assign wb.adr   = adr_q;
    assign wb.dat_w = dat_q;

endmodule

// File: tb/tb_wb_line_fetch128.sv
// Scoreboard bench for wb_line_fetch128 with a 2-cycle-latency slave model.
module tb_wb_line_fetch128;
    import wb_pkg::*;

    localparam int unsigned BEATS = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned TMO   = 16;
    localparam int unsigned LW    = 128 * BEATS;

    localparam word_t D0 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam word_t L0 = 128'hA0000000_00000000_00000000_000000A0;
    localparam word_t L1 = 128'hA1000000_11111111_00000000_000000A1;
    localparam word_t L2 = 128'hA2000000_22222222_00000000_000000A2;
    localparam word_t L3 = 128'hA3000000_33333333_00000000_000000A3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_i, req_line, req_we;
    logic [15:0]   req_sel;
    logic [AW-1:0] req_adr;
    word_t         req_dat;
    logic          req_rdy, resp_vld, resp_err;
    logic [LW-1:0] resp_dat;
    logic          slv_ack = 1'b0, inj_ack = 1'b0;
    word_t         slv_dat = '0;

    wb_line_fetch128_if #(.AW(AW)) bus ();
    assign bus.ack   = slv_ack | inj_ack;
    assign bus.dat_r = slv_dat;

    wb_line_fetch128 #(
        .BEATS(BEATS),
        .AW(AW),
        .TMO_CYCLES(TMO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .req_i(req_i),
        .req_line_i(req_line),
        .req_we_i(req_we),
        .req_sel_i(req_sel),
        .req_adr_i(req_adr),
        .req_dat_i(req_dat),
        .req_rdy_o(req_rdy),
        .resp_vld_o(resp_vld),
        .resp_err_o(resp_err),
        .resp_dat_o(resp_dat),
        .wb(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] adr;
        logic [2:0]    cti;
        logic          we;
        logic [15:0]   sel;
    } beat_t;

    typedef struct {
        logic [LW-1:0] dat;
        int            mode;  // 0: no data check, 1: low word, 2: full line
        logic          err;
        bit            lat;
    } resp_t;

    beat_t bus_exp[$];
    resp_t resp_exp[$];
    word_t mem [0:255];

    int n_chk = 0, n_pass = 0, n_resp = 0, exp_resp = 0;
    int ncyc = 0, last_ack_cyc = 0;
    int beat_n = 0, wcnt = 0, extra_beat = -1, extra_n = 0;
    bit noack = 1'b0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: event not as required", name);
    endtask

    task automatic push_beat(input logic [AW-1:0] adr, input logic [2:0] cti, input logic we);
        beat_t b;
        b.adr = adr; b.cti = cti; b.we = we; b.sel = 16'hFFFF;
        bus_exp.push_back(b);
    endtask

    task automatic push_resp(input logic [LW-1:0] dat, input int mode, input logic err,
                             input bit lat);
        resp_t r;
        r.dat = dat; r.mode = mode; r.err = err; r.lat = lat;
        resp_exp.push_back(r);
        exp_resp++;
    endtask

    task automatic issue(input bit line, input bit we, input logic [AW-1:0] adr, input word_t dat);
        int t = 0;
        @(negedge clk);
        while (!req_rdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_rdy) fail_now("rdy_wait");
        req_i = 1'b1; req_line = line; req_we = we; req_sel = 16'hFFFF;
        req_adr = adr; req_dat = dat;
        @(posedge clk);
        #1;
        chk("rdy_fall", req_rdy, 0);
        req_i = 1'b0;
    endtask

    task automatic wait_resp();
        int t = 0;
        while (n_resp < exp_resp && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("resp_count", n_resp, exp_resp);
    endtask

    always @(posedge clk) ncyc++;

    // Slave: acks after 2 cycles of strobe (plus optional waits on one beat).
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                slv_ack = 1'b0; wcnt = 0; beat_n = 0;
            end else if (slv_ack) begin
                slv_ack = 1'b0;
                beat_n++;
            end else if (bus.cyc && bus.stb && !noack) begin
                if (beat_n == extra_beat && wcnt > 0 && bus_exp.size() > 0)
                    chk("adr_hold", bus.adr, bus_exp[0].adr);
                wcnt++;
                if (wcnt >= 2 + ((beat_n == extra_beat) ? extra_n : 0)) begin
                    wcnt = 0;
                    slv_ack = 1'b1;
                    last_ack_cyc = ncyc;
                    if (bus_exp.size() == 0) begin
                        fail_now("bus_unexpected");
                    end else begin
                        beat_t e;
                        e = bus_exp.pop_front();
                        chk("adr_o", bus.adr, e.adr);
                        chk("cti_o", bus.cti, e.cti);
                        chk("we_o", bus.we, e.we);
                        chk("sel_o", bus.sel, e.sel);
                    end
                    if (bus.we) mem[bus.adr[11:4]] = bus.dat_w;
                    else slv_dat = mem[bus.adr[11:4]];
                end
            end else if (!bus.cyc) begin
                beat_n = 0; wcnt = 0;
            end
        end
    end

    // Response monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_vld) begin
                n_resp++;
                if (resp_exp.size() == 0) begin
                    fail_now("resp_unexpected");
                end else begin
                    resp_t r;
                    r = resp_exp.pop_front();
                    chk("resp_err", resp_err, r.err);
                    if (r.mode == 1) chk("resp_word", resp_dat[127:0], r.dat[127:0]);
                    if (r.mode == 2) chk("resp_line", resp_dat, r.dat);
                    if (r.lat) chk("resp_latency", ncyc, last_ack_cyc + 1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1);
    end

    initial begin
        int t;
        int hi;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h20] = L0; mem[8'h21] = L1; mem[8'h22] = L2; mem[8'h23] = L3;
        rst = 1'b1; req_i = 1'b0; req_line = 1'b0; req_we = 1'b0;
        req_sel = '0; req_adr = '0; req_dat = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", req_rdy, 1);
        chk("rst_vld", resp_vld, 0);
        chk("rst_err", resp_err, 0);
        chk("rst_cyc", bus.cyc, 0);
        chk("rst_stb", bus.stb, 0);
        chk("rst_cti", bus.cti, 0);
        chk("rst_adr", bus.adr, 0);
        chk("rst_sel", bus.sel, 0);
        chk("rst_dat", resp_dat, 0);
        rst = 1'b0;

        // Single write then read back.
        push_beat(32'h100, CTI_CLASSIC, 1'b1);
        push_resp('0, 0, 1'b0, 1'b1);
        issue(1'b0, 1'b1, 32'h100, D0);
        wait_resp();
        chk("mem_word_010", mem[8'h10], D0);

        push_beat(32'h100, CTI_CLASSIC, 1'b0);
        push_resp({{(LW-128){1'b0}}, D0}, 1, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 32'h100, '0);
        wait_resp();

        // Stray ack on an idle bus.
        @(negedge clk); inj_ack = 1'b1;
        @(negedge clk);
        chk("idle_ack_cyc", bus.cyc, 0);
        @(negedge clk); inj_ack = 1'b0;
        chk("idle_ack_rdy", req_rdy, 1);

        // Line fill, no waits, then with 3 waits on beat 2 plus an ignored request.
        for (int pass = 0; pass < 2; pass++) begin
            push_beat(32'h200, CTI_INCR, 1'b0);
            push_beat(32'h210, CTI_INCR, 1'b0);
            push_beat(32'h220, CTI_INCR, 1'b0);
            push_beat(32'h230, CTI_EOB, 1'b0);
            push_resp({L3, L2, L1, L0}, 2, 1'b0, 1'b1);
            if (pass == 1) begin
                extra_beat = 2; extra_n = 3;
            end
            issue(1'b1, 1'b0, 32'h234, '0);
            if (pass == 1) begin
                repeat (2) @(negedge clk);
                req_i = 1'b1; req_line = 1'b0; req_we = 1'b1; req_adr = 32'h800; req_dat = D0;
                repeat (2) @(negedge clk);
                req_i = 1'b0;
            end
            wait_resp();
            extra_beat = -1; extra_n = 0;
        end
        chk("ignored_req", mem[8'h80], 0);

        // Reset during beat 1 of a burst.
        push_beat(32'h300, CTI_INCR, 1'b0);
        issue(1'b1, 1'b0, 32'h300, '0);
        t = 0;
        while (beat_n != 1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("reached_beat1", beat_n, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_cyc", bus.cyc, 0);
        chk("rst_async_stb", bus.stb, 0);
        chk("rst_async_rdy", req_rdy, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_resp_after_rst", n_resp, exp_resp);
        chk("bus_exp_drained", bus_exp.size(), 0);

        push_beat(32'h100, CTI_CLASSIC, 1'b0);
        push_resp({{(LW-128){1'b0}}, D0}, 1, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 32'h100, '0);
        wait_resp();

`ifdef WB_LINE_FETCH128_TMO_EN
        noack = 1'b1;
        push_resp('0, 0, 1'b1, 1'b0);
        issue(1'b0, 1'b0, 32'hFF0, '0);
        hi = 0; t = 0;
        while (t < 100) begin
            @(negedge clk);
            t++;
            if (bus.cyc) hi++;
            else break;
        end
        chk("tmo_cyc_len", hi, TMO);
        wait_resp();
        noack = 1'b0;
        @(negedge clk);
        chk("tmo_back_idle", req_rdy, 1);
`endif

        repeat (3) @(negedge clk);
        chk("resp_exp_empty", resp_exp.size(), 0);
        chk("bus_exp_empty", bus_exp.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
